// File: rtl/alu_issue_pipe_pkg.sv
// ALU issue pipe shared definitions.
// ALU op encodings, MIPS opcode/funct constants, decode bundle.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_NOR  = 3'd5,
    ALU_SLT  = 3'd6,
    ALU_SLTU = 3'd7
  } alu_op_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  typedef struct packed {
    alu_op_e op;
    logic    imm_sel;
    logic    sign_ext;
    logic    branch;
    logic    bne;
    logic    illegal;
  } dec_t;

endpackage

// File: rtl/alu_issue_pipe_if.sv
// ALU issue pipe bus: upstream handshake, ALU port,
// downstream handshake and illegal counter.
interface alu_issue_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic [15:0]      imm;
  logic             flush;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_control;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_branch;
  logic             out_taken;
  logic             out_illegal;
  logic [7:0]       illegal_count;

  modport master (
    output in_valid, opcode, funct,
    output rs_val, rt_val, imm, flush,
    output alu_result, alu_zero, out_ready,
    input  in_ready, alu_a, alu_b,
    input  alu_control, out_valid,
    input  out_result, out_branch,
    input  out_taken, out_illegal,
    input  illegal_count
  );

  modport slave (
    input  in_valid, opcode, funct,
    input  rs_val, rt_val, imm, flush,
    input  alu_result, alu_zero, out_ready,
    output in_ready, alu_a, alu_b,
    output alu_control, out_valid,
    output out_result, out_branch,
    output out_taken, out_illegal,
    output illegal_count
  );
endinterface

// File: rtl/alu_issue_pipe_decode.sv
// Combinational MIPS opcode/funct decoder.
// Unknown encodings fall through to illegal.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output dec_t       o_dec
);

  // map {opcode, funct} onto ALU op and operand select
  always_comb begin
    o_dec = '{op: ALU_ADD, imm_sel: 1'b0,
              sign_ext: 1'b0, branch: 1'b0,
              bne: 1'b0, illegal: 1'b1};
    unique case (1'b1)
      (i_opcode == OP_RTYPE): begin
        o_dec.illegal = 1'b0;
        unique case (i_funct)
          F_ADD, F_ADDU: o_dec.op = ALU_ADD;
          F_SUB, F_SUBU: o_dec.op = ALU_SUB;
          F_AND:         o_dec.op = ALU_AND;
          F_OR:          o_dec.op = ALU_OR;
          F_XOR:         o_dec.op = ALU_XOR;
          F_NOR:         o_dec.op = ALU_NOR;
          F_SLT:         o_dec.op = ALU_SLT;
          F_SLTU:        o_dec.op = ALU_SLTU;
          default:       o_dec.illegal = 1'b1;
        endcase
      end
      (i_opcode == OP_BEQ),
      (i_opcode == OP_BNE): begin
        o_dec.illegal = 1'b0;
        o_dec.op      = ALU_SUB;
        o_dec.branch  = 1'b1;
        o_dec.bne     = (i_opcode == OP_BNE);
      end
      (i_opcode == OP_ADDI),
      (i_opcode == OP_ADDIU): begin
        o_dec.illegal  = 1'b0;
        o_dec.op       = ALU_ADD;
        o_dec.imm_sel  = 1'b1;
        o_dec.sign_ext = 1'b1;
      end
      (i_opcode == OP_SLTI): begin
        o_dec.illegal  = 1'b0;
        o_dec.op       = ALU_SLT;
        o_dec.imm_sel  = 1'b1;
        o_dec.sign_ext = 1'b1;
      end
      (i_opcode == OP_SLTIU): begin
        o_dec.illegal  = 1'b0;
        o_dec.op       = ALU_SLTU;
        o_dec.imm_sel  = 1'b1;
        o_dec.sign_ext = 1'b1;
      end
      (i_opcode == OP_ANDI): begin
        o_dec.illegal = 1'b0;
        o_dec.op      = ALU_AND;
        o_dec.imm_sel = 1'b1;
      end
      (i_opcode == OP_ORI): begin
        o_dec.illegal = 1'b0;
        o_dec.op      = ALU_OR;
        o_dec.imm_sel = 1'b1;
      end
      (i_opcode == OP_XORI): begin
        o_dec.illegal = 1'b0;
        o_dec.op      = ALU_XOR;
        o_dec.imm_sel = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue_pipe.sv
// Two-stage ALU issue pipe: I drives external ALU,
// R captures its result for a valid/ready consumer.
module alu_issue_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           rst_n,
  alu_issue_pipe_if.slave bus
);

  dec_t             w_dec;
  logic [WIDTH-1:0] w_imm;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_cap;
  logic             w_acc;
  logic             w_ohs;

  logic             r_i_valid;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  alu_op_e          r_alu_ctl;
  logic             r_i_branch;
  logic             r_i_bne;
  logic             r_i_illegal;

  logic             r_r_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_branch;
  logic             r_taken;
  logic             r_illegal;
  logic [7:0]       r_ill_cnt;

  alu_op_decode u_dec (
    .i_opcode (bus.opcode),
    .i_funct  (bus.funct),
    .o_dec    (w_dec)
  );

  assign w_imm = w_dec.sign_ext
    ? {{(WIDTH-16){bus.imm[15]}}, bus.imm}
    : {{(WIDTH-16){1'b0}}, bus.imm};

  assign w_a = w_dec.illegal ? '0 : bus.rs_val;
  assign w_b = w_dec.illegal ? '0
             : (w_dec.imm_sel ? w_imm : bus.rt_val);

  assign w_cap = r_i_valid && !bus.flush
              && (!r_r_valid || bus.out_ready);
  assign w_ohs = r_r_valid && bus.out_ready;
  assign bus.in_ready = !bus.flush
                     && (!r_i_valid || w_cap);
  assign w_acc = bus.in_valid && bus.in_ready;

  // issue stage: load decoded operands on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i_valid   <= 1'b0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_ctl   <= ALU_ADD;
      r_i_branch  <= 1'b0;
      r_i_bne     <= 1'b0;
      r_i_illegal <= 1'b0;
    end else begin
      if (bus.flush)  r_i_valid <= 1'b0;
      else if (w_acc) r_i_valid <= 1'b1;
      else if (w_cap) r_i_valid <= 1'b0;
      if (w_acc) begin
        r_alu_a     <= w_a;
        r_alu_b     <= w_b;
        r_alu_ctl   <= w_dec.op;
        r_i_branch  <= w_dec.branch;
        r_i_bne     <= w_dec.bne;
        r_i_illegal <= w_dec.illegal;
      end
    end
  end

  // result stage: capture ALU output, hold under stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_r_valid <= 1'b0;
      r_result  <= '0;
      r_branch  <= 1'b0;
      r_taken   <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      if (bus.flush)  r_r_valid <= 1'b0;
      else if (w_cap) r_r_valid <= 1'b1;
      else if (w_ohs) r_r_valid <= 1'b0;
      if (w_cap) begin
        r_result  <= r_i_illegal ? '0 : bus.alu_result;
        r_taken   <= r_i_branch
                  && (r_i_bne ^ bus.alu_zero);
        r_branch  <= r_i_branch;
        r_illegal <= r_i_illegal;
      end
    end
  end

  // count retired illegal results, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ill_cnt <= 8'd0;
    end else if (w_ohs && r_illegal && !bus.flush
                 && r_ill_cnt != 8'hFF) begin
      r_ill_cnt <= r_ill_cnt + 8'd1;
    end
  end

  assign bus.alu_a         = r_alu_a;
  assign bus.alu_b         = r_alu_b;
  assign bus.alu_control   = r_alu_ctl;
  assign bus.out_valid     = r_r_valid;
  assign bus.out_result    = r_result;
  assign bus.out_branch    = r_branch;
  assign bus.out_taken     = r_taken;
  assign bus.out_illegal   = r_illegal;
  assign bus.illegal_count = r_ill_cnt;

endmodule

// File: doc/alu_issue_pipe.md
ALU_ISSUE_PIPE -- requirements
Module: alu_issue_pipe

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream presents a decoded instruction.
REQ-005 in_ready  output  1  block accepts an instruction this cycle.
REQ-006 opcode  input  6  MIPS primary opcode.
REQ-007 funct  input  6  MIPS funct field, used only when opcode==0.
REQ-008 rs_val  input  WIDTH  first source operand.
REQ-009 rt_val  input  WIDTH  second source operand.
REQ-010 imm  input  16  immediate field.
REQ-011 flush  input  1  discards all in-flight instructions.
REQ-012 alu_a, alu_b  output  WIDTH  operands driven to the external ALU.
REQ-013 alu_control  output  3  ALU op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU.
REQ-014 alu_result  input  WIDTH  combinational ALU result for alu_a/alu_b/alu_control.
REQ-015 alu_zero  input  1  ALU zero flag.
REQ-016 out_valid  output  1  captured result available.
REQ-017 out_ready  input  1  downstream accepts the result.
REQ-018 out_result  output  WIDTH  captured ALU result.
REQ-019 out_branch, out_taken, out_illegal  output  1 each  branch instruction, branch taken, undecodable instruction.
REQ-020 illegal_count  output  8  saturating count of illegal instructions retired.

Function
REQ-021 Two registered stages SHALL exist: issue stage I (drives ALU ports) and result stage R (drives out_*); latency from in_valid&&in_ready to out_valid is exactly 2 cycles with out_ready held high.
REQ-022 Decode (combinational on inputs, registered into I): R-type funct 0x20/0x21->0, 0x22/0x23->1, 0x24->2, 0x25->3, 0x26->4, 0x27->5, 0x2A->6, 0x2B->7.
REQ-023 I-type: ADDI 0x08/ADDIU 0x09->0, SLTI 0x0A->6, SLTIU 0x0B->7, all with sign-extended imm as B; ANDI 0x0C->2, ORI 0x0D->3, XORI 0x0E->4 with zero-extended imm as B.
REQ-024 BEQ 0x04 and BNE 0x05 SHALL issue op 1 with B=rt_val and set branch flag; out_taken = alu_zero for BEQ, !alu_zero for BNE, 0 for non-branches.
REQ-025 Any other opcode/funct SHALL set illegal flag, issue op 0 with A=B=0; out_result=0, out_taken=0.
REQ-026 alu_a/alu_b/alu_control SHALL be driven directly from I registers; when I is empty they hold last values.
REQ-027 R captures {alu_result, alu_zero-derived taken, branch, illegal} when I valid and (R empty or out_ready).
REQ-028 in_ready = !I_valid || R captures this cycle (full throughput, one instruction per cycle).
REQ-029 out_* SHALL hold stable while out_valid && !out_ready.
REQ-030 flush SHALL clear I_valid and R_valid next edge and force in_ready=0 that cycle; an instruction offered during flush is dropped.
REQ-031 illegal_count SHALL increment when R output with out_illegal completes a handshake (out_valid&&out_ready), saturating at 255; flushed instructions are not counted.

Reset
REQ-032 rst_n low SHALL immediately clear I_valid, R_valid, out_result, out_branch, out_taken, out_illegal, alu_a, alu_b, alu_control, illegal_count to 0; in_ready=1 after reset release.
REQ-033 Reset mid-operation SHALL discard in-flight instructions without emitting them.

Structure
REQ-034 Shared package alu_pkg SHALL hold ALU op encodings (3-bit), opcode and funct constants.
REQ-035 One sub-module alu_op_decode SHALL be purely combinational: {opcode, funct} -> {alu_control, imm_sel, sign_ext, branch, bne, illegal}.

Verification
REQ-036 ADD rs=5, rt=7 (op 0, funct 0x20), out_ready=1 -> out_valid 2 cycles later, out_result=12, alu_control=0.
REQ-037 SLTI rs=0xFFFFFFFF, imm=0x0001 -> out_result=1; SLTIU same operands -> B=1, out_result=0.
REQ-038 BEQ rs=rt=9 -> out_branch=1, out_taken=1; BNE same -> out_taken=0; ORI imm=0x8000 -> B=0x00008000.
REQ-039 Back-to-back 4 instructions with out_ready low 3 cycles -> in_ready drops after 2 accepted, out_result holds, all 4 emitted in order, none lost.
REQ-040 opcode 0x3F twice then flush with 1 in flight -> out_illegal=1, illegal_count=1; 260 illegal retirements -> illegal_count=255.
REQ-041 rst_n asserted while both stages valid -> all outputs 0 asynchronously, no out_valid after release.
